// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake head stepper.
//   - Heading codes (2-bit): left, right, up, down.
//   - FSM state encoding for the stepper.
//   - decode_dir(): 3-bit keypad direction word -> heading code.
//   - is_reversal(): true when a requested heading is the 180-degree opposite of the current one.
package snake_pkg;

   localparam logic [1:0] HEAD_LEFT  = 2'b00;
   localparam logic [1:0] HEAD_RIGHT = 2'b01;
   localparam logic [1:0] HEAD_UP    = 2'b10;
   localparam logic [1:0] HEAD_DOWN  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_e;

   // Bit2 selects the axis; the bit belonging to the other axis is ignored.
   function automatic logic [1:0] decode_dir(input logic [2:0] dir);
      return dir[2] ? {1'b1, dir[1]} : {1'b0, dir[0]};
   endfunction

   // Same axis, opposite sense.
   function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] cur);
      return (req[1] == cur[1]) && (req[0] != cur[0]);
   endfunction

endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: modulo-TICK_DIV counter that paces the game.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en_i         : count enable; when low the counter holds its value
//   clr_i        : synchronous clear to 0, overrides en_i
//   tick_o       : high for the one cycle in which the count is TICK_DIV-1 while enabled
module game_tick_gen #(
   parameter int unsigned TICK_DIV = 12_500_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: validates keypad direction requests and advances the snake head one cell
// per game tick, with wrap-around or wall death at the grid edges.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   dir_in[2:0]      : direction word (bit2 axis, bit1 up/down, bit0 left/right)
//   dir_valid        : dir_in is meaningful while high
//   restart          : synchronous return to IDLE with head at the start cell
//   head_x, head_y   : current head cell
//   heading          : committed heading (00 left, 01 right, 10 up, 11 down)
//   step_pulse       : one cycle, coincident with the first cycle showing the moved head
//   running          : high in RUN
//   game_over        : high in DEAD
module snake_head_stepper
   import snake_pkg::*;
#(
   parameter int unsigned GRID_W   = 40,
   parameter int unsigned GRID_H   = 30,
   parameter int unsigned XW       = 6,
   parameter int unsigned YW       = 5,
   parameter int unsigned START_X  = 20,
   parameter int unsigned START_Y  = 15,
   parameter int unsigned TICK_DIV = 12_500_000,
   parameter bit          WRAP     = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    dir_in,
   input  logic          dir_valid,
   input  logic          restart,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y,
   output logic [1:0]    heading,
   output logic          step_pulse,
   output logic          running,
   output logic          game_over
);

   localparam logic [XW-1:0] X_LAST  = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(GRID_H - 1);
   localparam logic [XW-1:0] X_START = XW'(START_X);
   localparam logic [YW-1:0] Y_START = YW'(START_Y);

   state_e        state_q;
   logic [XW-1:0] head_x_q;
   logic [YW-1:0] head_y_q;
   logic [1:0]    heading_q;
   logic [1:0]    pend_dir_q;
   logic          pend_valid_q;
   logic          step_pulse_q;

   logic          tick;
   logic [1:0]    req;
   logic          req_ok;
   logic [1:0]    eff_dir;
   logic [XW-1:0] next_x;
   logic [YW-1:0] next_y;
   logic          wall_hit;

   game_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset_n(reset_n),
      .en_i   (state_q == ST_RUN),
      .clr_i  (restart || (state_q == ST_IDLE)),
      .tick_o (tick)
   );

   // A request is judged against the committed heading, never against a pending one.
   assign req    = decode_dir(dir_in);
   assign req_ok = dir_valid && (req != heading_q) && !is_reversal(req, heading_q);

   // A pending turn captured during a step cycle was judged against the pre-step heading, so
   // it is re-checked here and dropped if it has since become a reversal.
   assign eff_dir = (pend_valid_q && !is_reversal(pend_dir_q, heading_q)) ? pend_dir_q
                                                                          : heading_q;

   always_comb begin
      next_x   = head_x_q;
      next_y   = head_y_q;
      wall_hit = 1'b0;
      unique case (eff_dir)
         HEAD_LEFT: begin
            wall_hit = (head_x_q == '0);
            next_x   = wall_hit ? X_LAST : head_x_q - 1'b1;
         end
         HEAD_RIGHT: begin
            wall_hit = (head_x_q == X_LAST);
            next_x   = wall_hit ? '0 : head_x_q + 1'b1;
         end
         HEAD_UP: begin
            wall_hit = (head_y_q == '0);
            next_y   = wall_hit ? Y_LAST : head_y_q - 1'b1;
         end
         HEAD_DOWN: begin
            wall_hit = (head_y_q == Y_LAST);
            next_y   = wall_hit ? '0 : head_y_q + 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         head_x_q     <= X_START;
         head_y_q     <= Y_START;
         heading_q    <= HEAD_LEFT;
         pend_dir_q   <= HEAD_LEFT;
         pend_valid_q <= 1'b0;
         step_pulse_q <= 1'b0;
      end else begin
         step_pulse_q <= 1'b0;
         if (restart) begin
            state_q      <= ST_IDLE;
            head_x_q     <= X_START;
            head_y_q     <= Y_START;
            heading_q    <= HEAD_LEFT;
            pend_valid_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (dir_valid) begin
                     heading_q    <= req;
                     pend_valid_q <= 1'b0;
                     state_q      <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (tick) begin
                     if (wall_hit && !WRAP) begin
                        state_q      <= ST_DEAD;
                        pend_valid_q <= 1'b0;
                     end else begin
                        head_x_q     <= next_x;
                        head_y_q     <= next_y;
                        heading_q    <= eff_dir;
                        step_pulse_q <= 1'b1;
                        // Only a request arriving with no turn already queued survives the step.
                        pend_valid_q <= req_ok && !pend_valid_q;
                        if (req_ok && !pend_valid_q) begin
                           pend_dir_q <= req;
                        end
                     end
                  end else if (req_ok) begin
                     pend_dir_q   <= req;
                     pend_valid_q <= 1'b1;
                  end
               end
               ST_DEAD: begin
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign head_x     = head_x_q;
   assign head_y     = head_y_q;
   assign heading    = heading_q;
   assign step_pulse = step_pulse_q;
   assign running    = (state_q == ST_RUN);
   assign game_over  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: two instances (index 0 wraps at walls, index 1 dies at walls)
// share one directed stimulus. A cell/vector model predicts every output on every cycle, and
// literal checks pin the model at the points the scenario is built around.
module tb_snake_head_stepper;

   localparam int T  = 4;
   localparam int GW = 8;
   localparam int GH = 6;
   localparam int SX = 4;
   localparam int SY = 3;

   localparam int L = 0, R = 1, U = 2, D = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] dir_in = 3'b000;
   logic       dir_valid = 1'b0;
   logic       restart = 1'b0;

   logic [3:0] hx [2];
   logic [2:0] hy [2];
   logic [1:0] hd [2];
   logic       sp [2];
   logic       rn [2];
   logic       go [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   snake_head_stepper #(
      .GRID_W(GW), .GRID_H(GH), .XW(4), .YW(3), .START_X(SX), .START_Y(SY),
      .TICK_DIV(T), .WRAP(1'b1)
   ) u_wrap (
      .clk(clk), .reset_n(reset_n), .dir_in(dir_in), .dir_valid(dir_valid), .restart(restart),
      .head_x(hx[0]), .head_y(hy[0]), .heading(hd[0]), .step_pulse(sp[0]),
      .running(rn[0]), .game_over(go[0])
   );

   snake_head_stepper #(
      .GRID_W(GW), .GRID_H(GH), .XW(4), .YW(3), .START_X(SX), .START_Y(SY),
      .TICK_DIV(T), .WRAP(1'b0)
   ) u_wall (
      .clk(clk), .reset_n(reset_n), .dir_in(dir_in), .dir_valid(dir_valid), .restart(restart),
      .head_x(hx[1]), .head_y(hy[1]), .heading(hd[1]), .step_pulse(sp[1]),
      .running(rn[1]), .game_over(go[1])
   );

   task automatic chk(input string nm, input int inst, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", nm, inst, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int vx(input int h);
      return (h == L) ? -1 : (h == R) ? 1 : 0;
   endfunction
   function automatic int vy(input int h);
      return (h == U) ? -1 : (h == D) ? 1 : 0;
   endfunction
   function automatic bit opposite(input int a, input int b);
      return (vx(a) == -vx(b)) && (vy(a) == -vy(b));
   endfunction
   function automatic int dir_of(input logic [2:0] d);
      if (d[2]) return d[1] ? D : U;
      return d[0] ? R : L;
   endfunction

   int m_st [2], m_x [2], m_y [2], m_h [2], m_pd [2], m_run [2];
   bit m_pv [2], m_pulse [2];

   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n || restart) begin
            m_st[i] = M_IDLE; m_x[i] = SX; m_y[i] = SY; m_h[i] = L;
            m_pv[i] = 1'b0; m_pd[i] = L; m_run[i] = 0; m_pulse[i] = 1'b0;
         end else begin
            int  rq;
            bit  ok, step_now, was_pv;
            int  h, nx, ny;
            m_pulse[i] = 1'b0;
            rq = dir_of(dir_in);
            if (m_st[i] == M_IDLE) begin
               if (dir_valid) begin
                  m_h[i] = rq; m_pv[i] = 1'b0; m_st[i] = M_RUN; m_run[i] = 0;
               end
            end else if (m_st[i] == M_RUN) begin
               // Steps fall on every T-th cycle spent in RUN.
               step_now = ((m_run[i] + 1) % T) == 0;
               m_run[i]++;
               ok = dir_valid && (rq != m_h[i]) && !opposite(rq, m_h[i]);
               if (!step_now) begin
                  if (ok) begin m_pd[i] = rq; m_pv[i] = 1'b1; end
               end else begin
                  was_pv = m_pv[i];
                  h  = (m_pv[i] && !opposite(m_pd[i], m_h[i])) ? m_pd[i] : m_h[i];
                  nx = m_x[i] + vx(h);
                  ny = m_y[i] + vy(h);
                  if ((nx < 0 || nx >= GW || ny < 0 || ny >= GH) && i == 1) begin
                     m_st[i] = M_DEAD; m_pv[i] = 1'b0;
                  end else begin
                     m_x[i] = (nx + GW) % GW;
                     m_y[i] = (ny + GH) % GH;
                     m_h[i] = h;
                     m_pulse[i] = 1'b1;
                     m_pv[i] = ok && !was_pv;
                     if (ok && !was_pv) m_pd[i] = rq;
                  end
               end
            end
         end
      end
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < 2; i++) begin
            chk("head_x", i, int'(hx[i]), m_x[i]);
            chk("head_y", i, int'(hy[i]), m_y[i]);
            chk("heading", i, int'(hd[i]), m_h[i]);
            chk("step_pulse", i, int'(sp[i]), int'(m_pulse[i]));
            chk("running", i, int'(rn[i]), int'(m_st[i] == M_RUN));
            chk("game_over", i, int'(go[i]), int'(m_st[i] == M_DEAD));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] d);
      drive_edge();
      dir_in = d; dir_valid = 1'b1;
      drive_edge();
      dir_valid = 1'b0;
   endtask

   task automatic do_restart();
      drive_edge();
      restart = 1'b1;
      drive_edge();
      restart = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_pulse(input int inst);
      bit seen = 1'b0;
      for (int k = 0; k < 4 * T && !seen; k++) begin
         @(negedge clk);
         if (sp[inst]) seen = 1'b1;
      end
      chk("pulse_timeout", inst, int'(seen), 1);
   endtask

   task automatic lit(input int inst, input int x, input int y, input int h);
      chk("lit_x", inst, int'(hx[inst]), x);
      chk("lit_y", inst, int'(hy[inst]), y);
      chk("lit_heading", inst, int'(hd[inst]), h);
   endtask

   // ---------------- directed scenario ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Idle: nothing moves.
      repeat (20) @(negedge clk);
      lit(0, 4, 3, L);
      chk("lit_running", 0, int'(rn[0]), 0);

      // Right, then wrap at x=7 (instance 1 dies there instead).
      press(3'b001);
      @(negedge clk);
      chk("lit_running", 0, int'(rn[0]), 1);
      wait_pulse(0); lit(0, 5, 3, R);
      wait_pulse(0); lit(0, 6, 3, R);
      wait_pulse(0); lit(0, 7, 3, R);
      wait_pulse(0); lit(0, 0, 3, R);
      chk("lit_game_over", 1, int'(go[1]), 1);
      chk("lit_dead_x", 1, int'(hx[1]), 7);

      // Left is a reversal while heading right: ignored for two cycles.
      drive_edge();
      dir_in = 3'b010; dir_valid = 1'b1;
      drive_edge();
      drive_edge();
      dir_valid = 1'b0;
      wait_pulse(0); lit(0, 1, 3, R);

      // Up then down between steps: the later one wins.
      drive_edge();
      dir_in = 3'b101; dir_valid = 1'b1;
      drive_edge();
      dir_in = 3'b111;
      drive_edge();
      dir_valid = 1'b0;
      wait_pulse(0); lit(0, 1, 4, D);

      // Restart both, then head up: wrap vs wall death at y=0.
      do_restart();
      lit(0, 4, 3, L);
      chk("lit_game_over", 1, int'(go[1]), 0);
      press(3'b100);
      wait_pulse(0); lit(1, 4, 2, U);
      wait_pulse(0); lit(1, 4, 1, U);
      wait_pulse(0); lit(1, 4, 0, U);
      wait_pulse(0); lit(0, 4, 5, U);
      chk("lit_game_over", 1, int'(go[1]), 1);
      chk("lit_no_pulse", 1, int'(sp[1]), 0);
      repeat (10) @(negedge clk);
      lit(1, 4, 0, U);
      do_restart();
      lit(1, 4, 3, L);
      chk("lit_game_over", 1, int'(go[1]), 0);

      // Turn requested in the exact step cycle applies one step late.
      press(3'b001);
      wait_pulse(0); lit(0, 5, 3, R);
      drive_edge();
      drive_edge();
      drive_edge();
      dir_in = 3'b101; dir_valid = 1'b1;
      drive_edge();
      dir_valid = 1'b0;
      wait_pulse(0); lit(0, 6, 3, R);
      wait_pulse(0); lit(0, 6, 2, U);
      lit(1, 6, 2, U);

      // Asynchronous reset mid-run takes effect without a clock edge.
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      lit(0, 4, 3, L);
      chk("lit_reset_running", 0, int'(rn[0]), 0);
      chk("lit_reset_pulse", 0, int'(sp[0]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
